// File: rtl/jtag_vector_feeder_if.sv
// Host-side streams of the JTAG vector feeder: packed vector words in,
// captured TDO result words out.
interface jtag_vector_feeder_if;
  logic [31:0] in_data;
  logic [3:0]  in_len;
  logic        in_capture;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_len;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_len, in_capture, in_valid, out_ready,
    input  in_ready, out_data, out_len, out_valid
  );

  modport slave (
    input  in_data, in_len, in_capture, in_valid, out_ready,
    output in_ready, out_data, out_len, out_valid
  );
endinterface

// File: rtl/jtag_vector_feeder.sv
// Releases one TMS/TDI vector per get_next_data rising edge from a one-word
// buffer, and packs the lagged TDO samples back into result words.
module jtag_vector_feeder #(
  parameter int         TDO_LAG  = 2,
  parameter logic [1:0] IDLE_VEC = 2'b00
) (
  input  logic                 clk_max,
  input  logic                 rst,
  jtag_vector_feeder_if.slave  host,
  output logic [1:0]           vector_data,
  input  logic                 get_next_data,
  output logic                 data_ready,
  output logic                 wait_state,
  input  logic                 tdo,
  output logic                 overrun
);

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [3:0] len;
  } tag_t;

  logic        gnd_d_reg;
  logic        adv;
  logic [31:0] buf_data_reg;
  logic [3:0]  buf_len_reg;
  logic        buf_cap_reg;
  logic [3:0]  idx_reg;
  logic        buf_valid_reg;
  logic        accept;
  logic        buf_last;
  tag_t        new_tag;
  tag_t        tag_out;
  tag_t        pipe_reg [TDO_LAG];
  logic [15:0] cap_reg;
  logic [15:0] cap_next;
  logic [3:0]  cnt_reg;
  logic        take;
  logic        xfer;

  assign adv           = get_next_data & ~gnd_d_reg;
  assign accept        = host.in_valid & ~buf_valid_reg;
  assign host.in_ready = ~buf_valid_reg;
  assign buf_last      = (idx_reg == buf_len_reg);

  always_ff @(posedge clk_max or posedge rst) begin
    if (rst) gnd_d_reg <= 1'b0;
    else     gnd_d_reg <= get_next_data;
  end

  // Accept and drain are exclusive: a load only happens while the buffer is empty.
  always_ff @(posedge clk_max or posedge rst) begin
    if (rst) begin
      buf_data_reg  <= '0;
      buf_len_reg   <= '0;
      buf_cap_reg   <= 1'b0;
      idx_reg       <= '0;
      buf_valid_reg <= 1'b0;
    end else if (accept) begin
      buf_data_reg  <= host.in_data;
      buf_len_reg   <= host.in_len;
      buf_cap_reg   <= host.in_capture;
      idx_reg       <= '0;
      buf_valid_reg <= 1'b1;
    end else if (adv && buf_valid_reg) begin
      if (buf_last) buf_valid_reg <= 1'b0;
      else          idx_reg       <= idx_reg + 4'd1;
    end
  end

  always_ff @(posedge clk_max or posedge rst) begin
    if (rst) begin
      vector_data <= IDLE_VEC;
      data_ready  <= 1'b0;
      wait_state  <= 1'b1;
    end else if (adv) begin
      if (buf_valid_reg) begin
        vector_data <= buf_data_reg[{idx_reg, 1'b0} +: 2];
        data_ready  <= 1'b1;
        wait_state  <= 1'b0;
      end else begin
        vector_data <= IDLE_VEC;
        data_ready  <= 1'b0;
        wait_state  <= 1'b1;
      end
    end
  end

  always_comb begin
    new_tag = '0;
    if (buf_valid_reg) begin
      new_tag.valid = buf_cap_reg;
      new_tag.last  = buf_last;
      new_tag.len   = buf_len_reg;
    end
  end

  // Tag pipe delays each vector's identity until its TDO bit comes back.
  always_ff @(posedge clk_max or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TDO_LAG; i++) pipe_reg[i] <= '0;
    end else if (adv) begin
      pipe_reg[0] <= new_tag;
      for (int i = 1; i < TDO_LAG; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign tag_out  = pipe_reg[TDO_LAG-1];
  assign take     = adv & tag_out.valid;
  assign xfer     = take & tag_out.last;
  assign cap_next = cap_reg | (16'(tdo) << cnt_reg);

  always_ff @(posedge clk_max or posedge rst) begin
    if (rst) begin
      cap_reg <= '0;
      cnt_reg <= '0;
    end else if (take) begin
      if (tag_out.last) begin
        cap_reg <= '0;
        cnt_reg <= '0;
      end else begin
        cap_reg <= cap_next;
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

  // A finished word that finds the register still occupied is dropped.
  always_ff @(posedge clk_max or posedge rst) begin
    if (rst) begin
      host.out_data  <= '0;
      host.out_len   <= '0;
      host.out_valid <= 1'b0;
      overrun        <= 1'b0;
    end else if (xfer) begin
      if (!host.out_valid || host.out_ready) begin
        host.out_data  <= {16'b0, cap_next};
        host.out_len   <= tag_out.len;
        host.out_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (host.out_valid && host.out_ready) begin
      host.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_vector_feeder.sv
// Directed bench for jtag_vector_feeder with TDO_LAG=2 and IDLE_VEC=2'b00.
module tb_jtag_vector_feeder;
  logic       clk_max = 1'b0;
  logic       rst;
  logic       get_next_data;
  logic       tdo;
  logic [1:0] vector_data;
  logic       data_ready;
  logic       wait_state;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] WORD_A = 32'h1B1B_1B1B;
  localparam logic [31:0] WORD_B = 32'hE4E4_E4E4;

  always #5 clk_max = ~clk_max;

  jtag_vector_feeder_if ifc ();

  jtag_vector_feeder #(.TDO_LAG(2), .IDLE_VEC(2'b00)) dut (
    .clk_max       (clk_max),
    .rst           (rst),
    .host          (ifc),
    .vector_data   (vector_data),
    .get_next_data (get_next_data),
    .data_ready    (data_ready),
    .wait_state    (wait_state),
    .tdo           (tdo),
    .overrun       (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_max);
    #1;
  endtask

  // One advance event (E at the first edge) followed by a low cycle.
  task automatic e_pulse(input logic t);
    get_next_data = 1'b1;
    tdo           = t;
    tick();
    get_next_data = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] len, input logic cap);
    bit done = 0;
    ifc.in_data    = d;
    ifc.in_len     = len;
    ifc.in_capture = cap;
    ifc.in_valid   = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (ifc.in_ready) begin
        tick();
        done = 1;
        break;
      end
      tick();
    end
    ifc.in_valid = 1'b0;
    if (done) $display("send data=%h len=%0d cap=%0b", d, len, cap);
    else check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    get_next_data  = 1'b0;
    tdo            = 1'b0;
    ifc.in_data    = '0;
    ifc.in_len     = '0;
    ifc.in_capture = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.out_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_vec",      32'(vector_data),   32'd0);
    check_eq("rst_dready",   32'(data_ready),    32'd0);
    check_eq("rst_wait",     32'(wait_state),    32'd1);
    check_eq("rst_inready",  32'(ifc.in_ready),  32'd1);
    check_eq("rst_outvalid", 32'(ifc.out_valid), 32'd0);
    check_eq("rst_outdata",  ifc.out_data,       32'd0);
    check_eq("rst_outlen",   32'(ifc.out_len),   32'd0);
    check_eq("rst_overrun",  32'(overrun),       32'd0);
    rst = 1'b0;
    tick();

    // Single word: vectors 10 then 01, then idle
    send_word(32'h0000_0006, 4'd1, 1'b0);
    e_pulse(1'b0);
    check_eq("single_v0",     32'(vector_data), 32'h2);
    check_eq("single_dr0",    32'(data_ready),  32'd1);
    e_pulse(1'b0);
    check_eq("single_v1",     32'(vector_data), 32'h1);
    check_eq("single_dr1",    32'(data_ready),  32'd1);
    check_eq("single_inrdy",  32'(ifc.in_ready), 32'd1);
    e_pulse(1'b0);
    check_eq("single_idle",   32'(vector_data), 32'h0);
    check_eq("single_wait",   32'(wait_state),  32'd1);
    check_eq("single_dr2",    32'(data_ready),  32'd0);

    // Capture alignment: tdo 1,0,1,1 at E3..E6 -> 0xD
    send_word(32'h0000_00E4, 4'd3, 1'b1);
    e_pulse(1'b0);
    check_eq("cap_v0", 32'(vector_data), 32'h0);
    e_pulse(1'b0);
    check_eq("cap_v1", 32'(vector_data), 32'h1);
    e_pulse(1'b1);
    e_pulse(1'b0);
    e_pulse(1'b1);
    check_eq("cap_early_valid", 32'(ifc.out_valid), 32'd0);
    e_pulse(1'b1);
    check_eq("cap_valid", 32'(ifc.out_valid), 32'd1);
    check_eq("cap_data",  ifc.out_data,       32'h0000_000D);
    check_eq("cap_len",   32'(ifc.out_len),   32'd3);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_eq("cap_consumed", 32'(ifc.out_valid), 32'd0);

    // Back-to-back: 32 vectors without a bubble
    send_word(WORD_A, 4'd15, 1'b0);
    fork
      send_word(WORD_B, 4'd15, 1'b0);
      begin
        for (int i = 0; i < 32; i++) begin
          logic [31:0] w;
          w = (i < 16) ? WORD_A : WORD_B;
          e_pulse(1'b0);
          check_eq("b2b_vec",   32'(vector_data), 32'(w[2*(i%16) +: 2]));
          check_eq("b2b_ready", 32'(data_ready),  32'd1);
          check_eq("b2b_wait",  32'(wait_state),  32'd0);
        end
      end
    join
    e_pulse(1'b0);
    check_eq("b2b_tail_wait", 32'(wait_state), 32'd1);

    // Overrun: second result dropped while first is held
    send_word(32'h0000_0001, 4'd0, 1'b1);
    e_pulse(1'b0);
    send_word(32'h0000_0000, 4'd0, 1'b1);
    e_pulse(1'b0);
    e_pulse(1'b1);
    check_eq("ovr_first_valid", 32'(ifc.out_valid), 32'd1);
    check_eq("ovr_first_data",  ifc.out_data,       32'h1);
    check_eq("ovr_not_yet",     32'(overrun),       32'd0);
    e_pulse(1'b0);
    check_eq("ovr_flag",      32'(overrun),       32'd1);
    check_eq("ovr_held_data", ifc.out_data,       32'h1);
    check_eq("ovr_held_len",  32'(ifc.out_len),   32'd0);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_eq("ovr_drained", 32'(ifc.out_valid), 32'd0);
    check_eq("ovr_sticky",  32'(overrun),       32'd1);

    // Same-cycle accept and E with empty buffer
    ifc.in_data    = 32'h0000_0003;
    ifc.in_len     = 4'd0;
    ifc.in_capture = 1'b0;
    ifc.in_valid   = 1'b1;
    get_next_data  = 1'b1;
    tick();
    ifc.in_valid  = 1'b0;
    get_next_data = 1'b0;
    $display("send data=%h len=0 cap=0 (with E)", 32'h3);
    check_eq("same_idle",   32'(vector_data),  32'h0);
    check_eq("same_wait",   32'(wait_state),   32'd1);
    check_eq("same_loaded", 32'(ifc.in_ready), 32'd0);
    tick();
    e_pulse(1'b0);
    check_eq("same_next_vec", 32'(vector_data), 32'h3);
    check_eq("same_next_dr",  32'(data_ready),  32'd1);

    // Reset mid-word after 5 of 16 vectors
    e_pulse(1'b0);
    send_word(WORD_B, 4'd15, 1'b1);
    for (int i = 0; i < 5; i++) e_pulse(1'b1);
    check_eq("mid_busy", 32'(ifc.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_vec",      32'(vector_data),   32'd0);
    check_eq("mid_rst_dready",   32'(data_ready),    32'd0);
    check_eq("mid_rst_wait",     32'(wait_state),    32'd1);
    check_eq("mid_rst_inready",  32'(ifc.in_ready),  32'd1);
    check_eq("mid_rst_outvalid", 32'(ifc.out_valid), 32'd0);
    check_eq("mid_rst_overrun",  32'(overrun),       32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      e_pulse(1'b1);
      check_eq("post_rst_wait",     32'(wait_state),    32'd1);
      check_eq("post_rst_outvalid", 32'(ifc.out_valid), 32'd0);
    end
    check_eq("post_rst_inready", 32'(ifc.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jtag_vector_feeder.md
# jtag_vector_feeder

Upstream stage of the JTAG signal generator. It accepts packed 32-bit words of TMS/TDI vector pairs from the host-side stream and releases one 2-bit vector per TCK period, driven by the generator's `get_next_data` request pulse. It also collects the generator's sampled `tdo` bits, aligns each bit to the vector that produced it, and packs them into 32-bit result words for the host.

## Interface
Parameters:
- `TDO_LAG`, default 2: number of `get_next_data` rising edges between presenting a vector and capturing its TDO bit. Legal range 1..4.
- `IDLE_VEC`, default 2'b00: vector presented when no data is available (TMS=0 holds Run-Test/Idle).

Ports:
- `clk_max`  in  1  single clock, the same clock as the generator.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  32  packed vectors; vector i is `in_data[2i+1:2i]`, where bit 1 = TMS and bit 0 = TDI.
- `in_len`  in  4  number of valid vectors minus 1 (0 means 1 vector, 15 means 16 vectors).
- `in_capture`  in  1  capture TDO for this word's vectors.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid & in_ready`.
- `vector_data`  out  2  vector to the generator.
- `get_next_data`  in  1  generator request level; its rising edge is the advance event.
- `data_ready`  out  1  `vector_data` carries a real vector.
- `wait_state`  out  1  the idle vector is being presented (underrun).
- `tdo`  in  1  generator's sampled TDO.
- `out_data`  out  32  captured bits, LSB-first; unused high bits are 0.
- `out_len`  out  4  captured bit count minus 1.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  result word consumed when `out_valid & out_ready`.
- `overrun`  out  1  sticky: a result word was dropped.

## Operation
- **Word buffer:** one entry holding `buf_data`, `buf_len`, `buf_cap`, `idx[3:0]` and `buf_valid`.
  - `in_ready = !buf_valid`.
  - An accept loads the buffer and sets `idx=0`.
- **Advance event E:** `get_next_data & !gnd_d`, where `gnd_d` is `get_next_data` registered.
- **On E with `buf_valid`:**
  - `vector_data <= buf_data[2*idx+1 -: 2]`, `data_ready<=1`, `wait_state<=0`.
  - Push tag {valid=buf_cap, last=(idx==buf_len), len=buf_len} into the lag pipe.
  - If `idx==buf_len`, clear `buf_valid`; otherwise increment `idx`.
- **On E with the buffer empty:** `vector_data<=IDLE_VEC`, `data_ready<=0`, `wait_state<=1`, push a tag with valid=0.
- **Same-cycle accept and E with the buffer empty:** E sees empty and presents the idle vector. The new word is presented starting at the next E.
- **Lag pipe:** `TDO_LAG` stages, shifted only on E.
  - On E, the tag leaving the pipe qualifies the current `tdo`.
  - If that tag is valid, write `tdo` into `cap[cnt]` and increment `cnt`.
  - If the tag is also `last`, transfer {cap, len} to the output register, then clear `cap` to 0 and `cnt` to 0.
- **Output register:**
  - `out_valid` is set on transfer and cleared on `out_valid & out_ready`.
  - If a transfer occurs while `out_valid & !out_ready`, the new word is dropped, `overrun<=1`, and the register is unchanged.
  - If `out_ready` is high in the same cycle as a transfer with the register occupied, the old word leaves and the new word loads; no overrun.
- `overrun` clears only on `rst`.

## Timing
- **Reset values:** `vector_data=IDLE_VEC`, `data_ready=0`, `wait_state=1`, `in_ready=1`, `out_valid=0`, `out_data=0`, `out_len=0`, `overrun=0`. The lag pipe and `gnd_d` are cleared.
- **Mid-operation reset:** discards the buffer, the pipe, and any partial capture.
- **Vector latency:** E is detected in cycle N; `vector_data` is valid from N+1 until the next E. The generator latches it at its counter max, at least half a TCK period later.
- **Result latency:** `out_valid` rises the cycle after the E that captures the last bit.
- **Input acceptance:** `in_ready` returns high the cycle after the E that consumes the last vector. The next word can be accepted that same cycle.
- **Throughput:** one vector per E. There is no bubble between back-to-back words if the next word is accepted before the following E.

## Test plan
- **Single word:** reset, then `in_data=32'h0000_0006`, `in_len=1`, `in_capture=0`.
  - Required: across two E pulses, `vector_data` = 2'b10 then 2'b01, `data_ready=1`.
  - The third E gives `IDLE_VEC` with `wait_state=1`.
- **Capture alignment:** `TDO_LAG=2`, a 4-vector word with capture enabled, `tdo` forced to 1,0,1,1 at E edges 3..6.
  - Required: `out_data=32'h0000_000D`, `out_len=3`, `out_valid=1`.
- **Back-to-back:** two 16-vector words, the second accepted during the first.
  - Required: 32 consecutive E pulses give `data_ready=1` and `wait_state` never asserts.
- **Overrun:** two 1-vector capture words with `out_ready=0`.
  - Required: the first result is held, `overrun=1` after the second result, and `out_data` still shows the first.
- **Same-cycle accept + E with empty buffer:** that E presents `IDLE_VEC`; the next E presents vector 0.
- **Reset mid-word:** assert `rst` after 5 of 16 vectors.
  - Required: all outputs return to reset values immediately; after release, the buffer is empty, `in_ready=1`, and no `out_valid` appears.
